out_shift_reg: RTL and testbench

- Output shift register (OSR) for one PIO state machine.
- Sits directly downstream of the state machine's clock divider and consumes its penable strobe.
- Every state change is qualified by penable=1.
- Loads 32-bit words from the TX FIFO (explicit PULL or autopull), or from a scratch value (MOV), and shifts 1..32 bits out per OUT operation to the pin/destination logic.

---
 rtl/out_shift_reg_pkg.sv | 11 +
 rtl/out_shift_reg_osr_extract.sv | 30 +++
 rtl/out_shift_reg.sv | 117 +++++++++++
 tb/tb_out_shift_reg.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/out_shift_reg_pkg.sv
// Shared constants and count decode for the PIO output shift register.
package out_shift_reg_pkg;
  localparam int   OSR_W       = 32;
  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  // 5-bit bit counts encode 32 as 0
  function automatic logic [5:0] decode_cnt(input logic [4:0] c);
    return (c == 5'd0) ? 6'd32 : {1'b0, c};
  endfunction
endpackage

// File: rtl/out_shift_reg_osr_extract.sv
// Combinational bit extraction: returns the N bits leaving the word and the shifted remainder.
module osr_extract
  import out_shift_reg_pkg::*;
(
  input  logic [OSR_W-1:0] src,
  input  logic [5:0]       n,
  input  logic             dir,
  output logic [OSR_W-1:0] out_bits,
  output logic [OSR_W-1:0] shifted
);
  logic [OSR_W-1:0] mask;
  logic [4:0]       lsh;

  // n==32 takes the n[5] branch, so every shift below stays in 0..31
  assign mask = (32'd1 << n[4:0]) - 32'd1;
  assign lsh  = 5'd0 - n[4:0];

  always_comb begin
    if (n[5]) begin
      out_bits = src;
      shifted  = '0;
    end else if (dir == SHIFT_RIGHT) begin
      out_bits = src & mask;
      shifted  = src >> n[4:0];
    end else begin
      out_bits = src >> lsh;
      shifted  = src << n[4:0];
    end
  end
endmodule

// File: rtl/out_shift_reg.sv
// PIO output shift register: PULL/MOV loads, OUT shifts 1..32 bits per op.
// Define AUTOPULL_EN to build the autopull refill and idle-autopull logic.
module out_shift_reg
  import out_shift_reg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             penable,
  input  logic             shift_dir,
  input  logic             auto_pull,
  input  logic [4:0]       pull_thresh,
  input  logic             do_out,
  input  logic [4:0]       out_count,
  input  logic             do_pull,
  input  logic             pull_block,
  input  logic             if_empty,
  input  logic             do_mov,
  input  logic [OSR_W-1:0] mov_data,
  input  logic             tx_empty,
  input  logic [OSR_W-1:0] tx_data,
  output logic             tx_pop,
  output logic [OSR_W-1:0] out_data,
  output logic             out_valid,
  output logic             stall,
  output logic [5:0]       osr_count,
  output logic [OSR_W-1:0] osr_value
);
  logic [OSR_W-1:0] osr, osr_nxt, src, ext_bits, ext_shifted;
  logic [5:0]       cnt, cnt_nxt, thresh, n_bits, eff_cnt;
  logic [6:0]       cnt_sum;
  logic             ap, refill, out_ld;

`ifdef AUTOPULL_EN
  assign ap = auto_pull;
`else
  logic unused_auto_pull;
  assign unused_auto_pull = auto_pull;
  assign ap = 1'b0;
`endif

  assign thresh = decode_cnt(pull_thresh);
  assign n_bits = decode_cnt(out_count);
  assign refill = ap && (cnt >= thresh);

  // OUT source: on a refill the FIFO head is shifted directly, as if freshly loaded
  always_comb begin
    src     = refill ? tx_data : osr;
    eff_cnt = refill ? 6'd0 : cnt;
  end

  osr_extract u_extract (
    .src      (src),
    .n        (n_bits),
    .dir      (shift_dir),
    .out_bits (ext_bits),
    .shifted  (ext_shifted)
  );

  assign cnt_sum = {1'b0, eff_cnt} + {1'b0, n_bits};

  always_comb begin
    osr_nxt = osr;
    cnt_nxt = cnt;
    tx_pop  = 1'b0;
    stall   = 1'b0;
    out_ld  = 1'b0;
    if (!reset && penable) begin
      if (do_mov) begin
        osr_nxt = mov_data;
        cnt_nxt = 6'd0;
      end else if (do_pull) begin
        if (if_empty && (cnt < thresh)) begin
          osr_nxt = osr;
        end else if (!tx_empty) begin
          osr_nxt = tx_data;
          cnt_nxt = 6'd0;
          tx_pop  = 1'b1;
        end else if (pull_block) begin
          stall = 1'b1;
        end else begin
          osr_nxt = mov_data;
          cnt_nxt = 6'd0;
        end
      end else if (do_out) begin
        if (refill && tx_empty) begin
          stall = 1'b1;
        end else begin
          tx_pop  = refill;
          osr_nxt = ext_shifted;
          cnt_nxt = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];
          out_ld  = 1'b1;
        end
      end else if (refill && !tx_empty) begin
        osr_nxt = tx_data;
        cnt_nxt = 6'd0;
        tx_pop  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      osr       <= '0;
      cnt       <= 6'd32;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      osr       <= osr_nxt;
      cnt       <= cnt_nxt;
      out_valid <= out_ld;
      if (out_ld) out_data <= ext_bits;
    end
  end

  assign osr_count = cnt;
  assign osr_value = osr;
endmodule

// File: tb/tb_out_shift_reg.sv
// Directed bench for out_shift_reg with a per-cycle reference model.
module tb_out_shift_reg;
  logic        clk = 1'b0;
  logic        reset, penable, shift_dir, auto_pull, do_out, do_pull, pull_block;
  logic        if_empty, do_mov, tx_empty;
  logic [4:0]  pull_thresh, out_count;
  logic [31:0] mov_data, tx_data;
  logic        tx_pop, out_valid, stall;
  logic [31:0] out_data, osr_value;
  logic [5:0]  osr_count;

  int checks = 0;
  int errors = 0;

  out_shift_reg dut (
    .clk(clk), .reset(reset), .penable(penable), .shift_dir(shift_dir),
    .auto_pull(auto_pull), .pull_thresh(pull_thresh), .do_out(do_out),
    .out_count(out_count), .do_pull(do_pull), .pull_block(pull_block),
    .if_empty(if_empty), .do_mov(do_mov), .mov_data(mov_data),
    .tx_empty(tx_empty), .tx_data(tx_data), .tx_pop(tx_pop),
    .out_data(out_data), .out_valid(out_valid), .stall(stall),
    .osr_count(osr_count), .osr_value(osr_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, held as the values the registers must show
  logic [31:0] m_osr = 32'h0, m_out = 32'h0;
  int          m_cnt = 32;
  logic        m_vld = 1'b0;

  always @(negedge clk) begin
    int          t, n, c;
    logic        ap, e_stall, e_pop;
    logic [31:0] s;
    logic [63:0] w;
    chk("m_osr_value", osr_value, m_osr);
    chk("m_osr_count", 32'(osr_count), 32'(m_cnt));
    chk("m_out_valid", 32'(out_valid), 32'(m_vld));
    chk("m_out_data", out_data, m_out);
    t = (pull_thresh == 0) ? 32 : int'(pull_thresh);
    n = (out_count == 0) ? 32 : int'(out_count);
`ifdef AUTOPULL_EN
    ap = auto_pull;
`else
    ap = 1'b0;
`endif
    e_stall = 1'b0;
    e_pop   = 1'b0;
    if (reset) begin
      m_osr = 0; m_cnt = 32; m_out = 0; m_vld = 0;
    end else if (!penable) begin
      m_vld = 0;
    end else begin
      m_vld = 0;
      if (do_mov) begin
        m_osr = mov_data; m_cnt = 0;
      end else if (do_pull) begin
        if (if_empty && m_cnt < t) ;
        else if (!tx_empty) begin m_osr = tx_data; m_cnt = 0; e_pop = 1; end
        else if (pull_block) e_stall = 1;
        else begin m_osr = mov_data; m_cnt = 0; end
      end else if (do_out) begin
        if (ap && m_cnt >= t && tx_empty) e_stall = 1;
        else begin
          s = m_osr; c = m_cnt;
          if (ap && m_cnt >= t) begin s = tx_data; c = 0; e_pop = 1; end
          w = {32'h0, s};
          if (shift_dir) begin
            m_out = 32'(w % (64'd1 << n));
            m_osr = 32'(w >> n);
          end else begin
            w = w << n;
            m_out = 32'(w >> 32);
            m_osr = 32'(w);
          end
          m_cnt = (c + n > 32) ? 32 : c + n;
          m_vld = 1;
        end
      end else if (ap && m_cnt >= t && !tx_empty) begin
        m_osr = tx_data; m_cnt = 0; e_pop = 1;
      end
    end
    chk("m_stall", 32'(stall), 32'(e_stall));
    chk("m_tx_pop", 32'(tx_pop), 32'(e_pop));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ops();
    do_out = 0; do_pull = 0; do_mov = 0; if_empty = 0; pull_block = 0;
  endtask

  logic [31:0] bytes_exp [4] = '{32'hEF, 32'hBE, 32'hAD, 32'hDE};

  initial begin
    reset = 1; penable = 1; shift_dir = 1; auto_pull = 1; pull_thresh = 0;
    out_count = 0; mov_data = 0; tx_empty = 1; tx_data = 0;
    clr_ops();
    repeat (2) step();
    chk("rst_count", 32'(osr_count), 32'd32);
    chk("rst_osr", osr_value, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out", out_data, 32'h0);
    reset = 0;

    // First load of 0xDEADBEEF
    tx_empty = 0; tx_data = 32'hDEADBEEF;
`ifndef AUTOPULL_EN
    do_pull = 1;
`endif
    @(negedge clk); chk("load_pop", 32'(tx_pop), 32'd1);
    step();
    chk("load_osr", osr_value, 32'hDEADBEEF);
    chk("load_count", 32'(osr_count), 32'd0);
    clr_ops(); tx_empty = 1;

    // Four byte-wide right shifts
    do_out = 1; out_count = 8;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("byte_out", out_data, bytes_exp[i]);
      chk("byte_valid", 32'(out_valid), 32'd1);
    end
    chk("bytes_count", 32'(osr_count), 32'd32);
`ifdef AUTOPULL_EN
    @(negedge clk); chk("empty_stall", 32'(stall), 32'd1);
    step();
    chk("stall_count", 32'(osr_count), 32'd32);
    chk("stall_valid", 32'(out_valid), 32'd0);
    tx_empty = 0; tx_data = 32'h11223344;
    @(negedge clk); chk("refill_pop", 32'(tx_pop), 32'd1);
    step();
    chk("refill_out", out_data, 32'h44);
    chk("refill_osr", osr_value, 32'h00112233);
    chk("refill_count", 32'(osr_count), 32'd8);
    tx_empty = 1;
`else
    @(negedge clk); chk("noap_stall", 32'(stall), 32'd0);
    step();
    chk("noap_zero_out", out_data, 32'h0);
    chk("noap_count", 32'(osr_count), 32'd32);
`endif
    clr_ops();

    // Left shift of a MOV value
    shift_dir = 0; do_mov = 1; mov_data = 32'h80000001;
    step(); clr_ops();
    do_out = 1; out_count = 1;
    step();
    chk("left_out", out_data, 32'h1);
    chk("left_osr", osr_value, 32'h00000002);
    chk("left_count", 32'(osr_count), 32'd1);
    clr_ops();

    // Blocking PULL against an empty FIFO
    do_pull = 1; pull_block = 1; tx_empty = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("block_stall", 32'(stall), 32'd1);
      step();
    end
    chk("block_osr_held", osr_value, 32'h00000002);
    tx_empty = 0; tx_data = 32'h12345678;
    @(negedge clk); chk("block_pop", 32'(tx_pop), 32'd1);
    step();
    chk("block_osr", osr_value, 32'h12345678);
    tx_empty = 1; pull_block = 0; mov_data = 32'h55;
    @(negedge clk); chk("nb_pop", 32'(tx_pop), 32'd0);
    step();
    chk("nb_osr", osr_value, 32'h55);
    chk("nb_count", 32'(osr_count), 32'd0);
    clr_ops();

    // OUT stream under a 1-of-3 enable
    shift_dir = 1; do_mov = 1; mov_data = 32'hF0F0F0F0;
    step(); clr_ops();
    do_out = 1; out_count = 4;
    for (int i = 0; i < 9; i++) begin
      penable = (i % 3 == 0);
      step();
    end
    penable = 1; clr_ops();
    chk("pen_count", 32'(osr_count), 32'd12);
    chk("pen_osr", osr_value, 32'h000F0F0F);

    // PULL if_empty below and at threshold
    pull_thresh = 8; do_mov = 1; mov_data = 32'h0000ABCD;
    step(); clr_ops();
    do_out = 1; out_count = 4;
    step(); clr_ops();
    do_pull = 1; if_empty = 1; tx_empty = 0; tx_data = 32'hCAFEF00D;
    @(negedge clk); chk("ife_nop_pop", 32'(tx_pop), 32'd0);
    step();
    chk("ife_nop_osr", osr_value, 32'h00000ABC);
    chk("ife_nop_count", 32'(osr_count), 32'd4);
    clr_ops(); tx_empty = 1;
    do_out = 1; out_count = 4;
    step(); clr_ops();
    do_pull = 1; if_empty = 1; tx_empty = 0;
    @(negedge clk); chk("ife_pop", 32'(tx_pop), 32'd1);
    step();
    chk("ife_osr", osr_value, 32'hCAFEF00D);
    chk("ife_count", 32'(osr_count), 32'd0);
    clr_ops(); tx_empty = 1;

    // Full-word OUT, then a saturating OUT
    pull_thresh = 0; do_mov = 1; mov_data = 32'hA5A5A5A5;
    step(); clr_ops();
    do_out = 1; out_count = 0;
    step();
    chk("n32_out", out_data, 32'hA5A5A5A5);
    chk("n32_osr", osr_value, 32'h0);
    chk("n32_count", 32'(osr_count), 32'd32);
    out_count = 4;
    step();
    chk("sat_count", 32'(osr_count), 32'd32);
    clr_ops();

    // Reset while a blocking PULL stalls
    do_pull = 1; pull_block = 1; tx_empty = 1;
    @(negedge clk); chk("pre_rst_stall", 32'(stall), 32'd1);
    step();
    reset = 1;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_pop", 32'(tx_pop), 32'd0);
    step();
    reset = 0; clr_ops();
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
